// File: rtl/led_pkg.sv
// Shared constants for the RGB LED driver: colour bit positions, colour codes
// and the per-channel fade state encoding.
package led_pkg;

  // Bit position of each channel inside a colour code
  localparam int unsigned COL_R = 0;
  localparam int unsigned COL_G = 1;
  localparam int unsigned COL_B = 2;

  // Colour codes as produced by the colour sequencer
  localparam logic [2:0] OFF     = 3'd0;
  localparam logic [2:0] RED     = 3'd1;
  localparam logic [2:0] GREEN   = 3'd2;
  localparam logic [2:0] YELLOW  = 3'd3;
  localparam logic [2:0] BLUE    = 3'd4;
  localparam logic [2:0] MAGENTA = 3'd5;
  localparam logic [2:0] CYAN    = 3'd6;
  localparam logic [2:0] WHITE   = 3'd7;

  // Channel fade state
  typedef logic [1:0] ch_state_t;
  localparam ch_state_t IDLE    = 2'd0;
  localparam ch_state_t FADE_UP = 2'd1;
  localparam ch_state_t FADE_DN = 2'd2;

endpackage

// File: rtl/rgb_led_driver_if.sv
// Colour request / LED pin bundle between the colour sequencer (master) and
// the RGB LED driver (slave).
interface rgb_led_driver_if #(
  parameter int CNT_W = 8
);
  logic [2:0]       colour_in;
  logic             colour_vld;
  logic [CNT_W-1:0] brightness;
  logic [2:0]       colour_cur;
  logic             led_r;
  logic             led_g;
  logic             led_b;
  logic             busy;

  modport master (
    output colour_in, colour_vld, brightness,
    input  colour_cur, led_r, led_g, led_b, busy
  );

  modport slave (
    input  colour_in, colour_vld, brightness,
    output colour_cur, led_r, led_g, led_b, busy
  );
endinterface

// File: rtl/pwm_channel.sv
// One LED channel: target/duty registers, per-period fade step toward the
// target and the registered PWM compare.
module pwm_channel
  import led_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int FADE_STEP = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] tgt_in,
  input  logic             period_end,
  input  logic [CNT_W-1:0] pwm_cnt,
  output logic [CNT_W-1:0] duty,
  output logic             led,
  output ch_state_t        state
);

  localparam logic [CNT_W:0]   StepWide = (CNT_W + 1)'(FADE_STEP);
  localparam logic [CNT_W-1:0] Step     = CNT_W'(FADE_STEP);

  logic [CNT_W-1:0] tgt_q;
  logic [CNT_W-1:0] duty_q;
  logic [CNT_W-1:0] duty_d;
  logic [CNT_W:0]   diff_up;
  logic [CNT_W:0]   diff_dn;
  logic             led_q;

  // Next duty: snap to target when within one step, else move one step.
  // Differences use one extra bit so the compare never wraps.
  always_comb begin
    diff_up = {1'b0, tgt_q} - {1'b0, duty_q};
    diff_dn = {1'b0, duty_q} - {1'b0, tgt_q};
    duty_d  = duty_q;
    if (duty_q < tgt_q) begin
      duty_d = (diff_up <= StepWide) ? tgt_q : duty_q + Step;
    end else if (duty_q > tgt_q) begin
      duty_d = (diff_dn <= StepWide) ? tgt_q : duty_q - Step;
    end
  end

  // Fade state derived from the duty/target relation
  always_comb begin
    state = IDLE;
    if (duty_q < tgt_q) begin
      state = FADE_UP;
    end else if (duty_q > tgt_q) begin
      state = FADE_DN;
    end
  end

  // Target load, fade update on period end and registered PWM output.
  // All-ones duty forces the pin high so full brightness never blinks.
  always_ff @(posedge clk) begin
    if (rst) begin
      tgt_q  <= '0;
      duty_q <= '0;
      led_q  <= 1'b0;
    end else begin
      if (load) begin
        tgt_q <= tgt_in;
      end
      if (period_end) begin
        duty_q <= duty_d;
      end
      led_q <= (&duty_q) | (pwm_cnt < duty_q);
    end
  end

  assign duty = duty_q;
  assign led  = led_q;

endmodule

// File: rtl/rgb_led_driver.sv
// RGB LED driver: accepts a 3-bit colour code plus brightness and cross-fades
// three PWM channels toward it. Holds the shared prescaler and PWM counter.
module rgb_led_driver
  import led_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int PRESCALE  = 4,
  parameter int FADE_STEP = 16
) (
  input logic              clk,
  input logic              rst,
  rgb_led_driver_if.slave  bus
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0]    presc_q;
  logic [CNT_W-1:0] pwm_cnt_q;
  logic [2:0]       colour_cur_q;
  logic             tick;
  logic             period_end;
  logic [CNT_W-1:0] tgt_r;
  logic [CNT_W-1:0] tgt_g;
  logic [CNT_W-1:0] tgt_b;
  ch_state_t        st_r;
  ch_state_t        st_g;
  ch_state_t        st_b;
  logic [CNT_W-1:0] duty_r;
  logic [CNT_W-1:0] duty_g;
  logic [CNT_W-1:0] duty_b;

  assign tick       = (presc_q == PW'(PRESCALE - 1));
  assign period_end = tick & (&pwm_cnt_q);

  // Prescaler and PWM counter; the counter steps once per tick and wraps
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q   <= '0;
      pwm_cnt_q <= '0;
    end else if (tick) begin
      presc_q   <= '0;
      pwm_cnt_q <= pwm_cnt_q + 1'b1;
    end else begin
      presc_q   <= presc_q + 1'b1;
    end
  end

  // Every request is accepted, even mid-fade
  always_ff @(posedge clk) begin
    if (rst) begin
      colour_cur_q <= '0;
    end else if (bus.colour_vld) begin
      colour_cur_q <= bus.colour_in;
    end
  end

  assign tgt_r = bus.colour_in[COL_R] ? bus.brightness : '0;
  assign tgt_g = bus.colour_in[COL_G] ? bus.brightness : '0;
  assign tgt_b = bus.colour_in[COL_B] ? bus.brightness : '0;

  pwm_channel #(.CNT_W(CNT_W), .FADE_STEP(FADE_STEP)) u_ch_r (
    .clk       (clk),
    .rst       (rst),
    .load      (bus.colour_vld),
    .tgt_in    (tgt_r),
    .period_end(period_end),
    .pwm_cnt   (pwm_cnt_q),
    .duty      (duty_r),
    .led       (bus.led_r),
    .state     (st_r)
  );

  pwm_channel #(.CNT_W(CNT_W), .FADE_STEP(FADE_STEP)) u_ch_g (
    .clk       (clk),
    .rst       (rst),
    .load      (bus.colour_vld),
    .tgt_in    (tgt_g),
    .period_end(period_end),
    .pwm_cnt   (pwm_cnt_q),
    .duty      (duty_g),
    .led       (bus.led_g),
    .state     (st_g)
  );

  pwm_channel #(.CNT_W(CNT_W), .FADE_STEP(FADE_STEP)) u_ch_b (
    .clk       (clk),
    .rst       (rst),
    .load      (bus.colour_vld),
    .tgt_in    (tgt_b),
    .period_end(period_end),
    .pwm_cnt   (pwm_cnt_q),
    .duty      (duty_b),
    .led       (bus.led_b),
    .state     (st_b)
  );

  assign bus.colour_cur = colour_cur_q;
  assign bus.busy       = (st_r != IDLE) | (st_g != IDLE) | (st_b != IDLE);

endmodule

// File: tb/tb_rgb_led_driver.sv
// Bench for rgb_led_driver: vector table for the fade sequence, hand-written
// corner cases and randomized requests checked against a cycle-count model.
module tb_rgb_led_driver;
  import led_pkg::*;

  localparam int STEP = 64;
  localparam int PER  = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rgb_led_driver_if #(.CNT_W(8)) bus ();
  rgb_led_driver_if #(.CNT_W(8)) bus4 ();

  rgb_led_driver #(.CNT_W(8), .PRESCALE(1), .FADE_STEP(STEP)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  rgb_led_driver #(.CNT_W(8), .PRESCALE(4), .FADE_STEP(STEP)) dut4 (
    .clk(clk),
    .rst(rst),
    .bus(bus4)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: time counted in whole cycles since reset, a period is
  // PER cycles, duties move by STEP toward the target at each period end.
  int m_duty[3];
  int m_tgt[3];
  int m_led[3];
  int m_col;
  int mcyc;
  int m_pe_cnt = 0;

  always @(posedge clk) begin : model
    int cnt;
    if (rst) begin
      for (int c = 0; c < 3; c++) begin
        m_duty[c] = 0;
        m_tgt[c]  = 0;
        m_led[c]  = 0;
      end
      m_col = 0;
      mcyc  = 0;
    end else begin
      cnt = mcyc % PER;
      for (int c = 0; c < 3; c++) m_led[c] = (m_duty[c] == 255 || cnt < m_duty[c]) ? 1 : 0;
      if (mcyc % PER == PER - 1) begin
        for (int c = 0; c < 3; c++) begin
          if (m_tgt[c] > m_duty[c])
            m_duty[c] = (m_tgt[c] - m_duty[c] <= STEP) ? m_tgt[c] : m_duty[c] + STEP;
          else if (m_tgt[c] < m_duty[c])
            m_duty[c] = (m_duty[c] - m_tgt[c] <= STEP) ? m_tgt[c] : m_duty[c] - STEP;
        end
        m_pe_cnt++;
      end
      if (bus.colour_vld) begin
        m_col = int'(bus.colour_in);
        for (int c = 0; c < 3; c++) m_tgt[c] = bus.colour_in[c] ? int'(bus.brightness) : 0;
      end
      mcyc++;
    end
  end

  // Continuous comparison of the main DUT against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("led_r", int'(bus.led_r), m_led[0]);
      chk("led_g", int'(bus.led_g), m_led[1]);
      chk("led_b", int'(bus.led_b), m_led[2]);
      chk("busy", int'(bus.busy),
          (m_duty[0] != m_tgt[0] || m_duty[1] != m_tgt[1] || m_duty[2] != m_tgt[2]) ? 1 : 0);
      chk("colour_cur", int'(bus.colour_cur), m_col);
      chk("duty_r", int'(dut.u_ch_r.duty), m_duty[0]);
      chk("duty_g", int'(dut.u_ch_g.duty), m_duty[1]);
      chk("duty_b", int'(dut.u_ch_b.duty), m_duty[2]);
    end
  end

  task automatic wait_pe();
    int start;
    bit seen;
    start = m_pe_cnt;
    seen  = 1'b0;
    for (int i = 0; i < 2 * PER && !seen; i++) begin
      @(negedge clk);
      if (m_pe_cnt != start) seen = 1'b1;
    end
    if (!seen) chk("period_end_timeout", 0, 1);
  endtask

  task automatic request(input logic [2:0] col, input logic [7:0] bri);
    bus.colour_in  = col;
    bus.brightness = bri;
    bus.colour_vld = 1'b1;
    @(negedge clk);
    bus.colour_vld = 1'b0;
  endtask

  task automatic do_reset(input bit vld_during);
    rst = 1'b1;
    bus.colour_vld = vld_during;
    bus.colour_in  = WHITE;
    bus.brightness = 8'd255;
    repeat (3) @(negedge clk);
    bus.colour_vld = 1'b0;
    rst = 1'b0;
  endtask

  typedef struct {
    logic       vld;
    logic [2:0] col;
    logic [7:0] bri;
    int         er;
    int         eg;
    int         eb;
    int         ebusy;
  } vec_t;

  vec_t vt[8];

  initial begin
    int hi_r;
    int hi_g;
    int busy_cnt;
    int k;

    vt[0] = '{1'b1, RED,   8'd255, 64,  0,   0,   1};
    vt[1] = '{1'b0, OFF,   8'd0,   128, 0,   0,   1};
    vt[2] = '{1'b1, CYAN,  8'd255, 64,  64,  64,  1};
    vt[3] = '{1'b0, OFF,   8'd0,   0,   128, 128, 1};
    vt[4] = '{1'b0, OFF,   8'd0,   0,   192, 192, 1};
    vt[5] = '{1'b0, OFF,   8'd0,   0,   255, 255, 0};
    vt[6] = '{1'b1, CYAN,  8'd255, 0,   255, 255, 0};
    vt[7] = '{1'b1, WHITE, 8'd0,   0,   191, 191, 1};

    bus.colour_in   = OFF;
    bus.colour_vld  = 1'b0;
    bus.brightness  = 8'd0;
    bus4.colour_in  = OFF;
    bus4.colour_vld = 1'b0;
    bus4.brightness = 8'd0;

    // Reset values
    do_reset(1'b0);
    chk("rst_leds", int'({bus.led_r, bus.led_g, bus.led_b}), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_colour_cur", int'(bus.colour_cur), 0);
    chk_en = 1'b1;

    // Fade sequence table
    for (int i = 0; i < 8; i++) begin
      if (vt[i].vld) begin
        request(vt[i].col, vt[i].bri);
        chk($sformatf("vec%0d_busy_accept", i), int'(bus.busy), vt[i].ebusy);
      end
      wait_pe();
      chk($sformatf("vec%0d_duty_r", i), int'(dut.u_ch_r.duty), vt[i].er);
      chk($sformatf("vec%0d_duty_g", i), int'(dut.u_ch_g.duty), vt[i].eg);
      chk($sformatf("vec%0d_duty_b", i), int'(dut.u_ch_b.duty), vt[i].eb);
      chk($sformatf("vec%0d_busy", i), int'(bus.busy), vt[i].ebusy);
    end

    // Reset overrides a coincident request
    do_reset(1'b1);
    chk("rst_vld_colour_cur", int'(bus.colour_cur), 0);
    chk("rst_vld_busy", int'(bus.busy), 0);

    // Steady red at half brightness: 128 high cycles per period
    request(RED, 8'd128);
    wait_pe();
    wait_pe();
    hi_r = 0;
    hi_g = 0;
    for (int i = 0; i < PER; i++) begin
      @(negedge clk);
      hi_r += int'(bus.led_r);
      hi_g += int'(bus.led_g);
    end
    chk("half_r_high", hi_r, 128);
    chk("half_g_high", hi_g, 0);

    // Full red: pin never drops
    request(RED, 8'd255);
    wait_pe();
    wait_pe();
    hi_r = 0;
    for (int i = 0; i < PER; i++) begin
      @(negedge clk);
      hi_r += int'(bus.led_r);
    end
    chk("full_r_high", hi_r, PER);
    chk("full_busy", int'(bus.busy), 0);

    // Request on the exact period_end cycle: that update sees old targets
    k = 0;
    while (mcyc % PER != PER - 1 && k < 2 * PER) begin
      @(negedge clk);
      k++;
    end
    request(BLUE, 8'd200);
    chk("pe_vld_duty_r", int'(dut.u_ch_r.duty), 255);
    chk("pe_vld_duty_b", int'(dut.u_ch_b.duty), 0);
    chk("pe_vld_busy", int'(bus.busy), 1);
    wait_pe();
    chk("pe_vld_next_r", int'(dut.u_ch_r.duty), 191);
    chk("pe_vld_next_b", int'(dut.u_ch_b.duty), 64);

    // Reset in the middle of a fade
    do_reset(1'b1);
    chk("midrst_leds", int'({bus.led_r, bus.led_g, bus.led_b}), 0);
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_duty_b", int'(dut.u_ch_b.duty), 0);

    // White at zero brightness: nothing lights, never busy
    request(WHITE, 8'd0);
    busy_cnt = 0;
    hi_r = 0;
    for (int i = 0; i < PER + 40; i++) begin
      @(negedge clk);
      busy_cnt += int'(bus.busy);
      hi_r += int'(bus.led_r) + int'(bus.led_g) + int'(bus.led_b);
    end
    chk("white0_busy_cycles", busy_cnt, 0);
    chk("white0_led_high", hi_r, 0);
    chk("white0_colour_cur", int'(bus.colour_cur), 7);

    // Randomized requests; inputs wander between strobes and must be ignored
    for (int i = 0; i < 8000; i++) begin
      bus.colour_in  = 3'($urandom_range(0, 7));
      bus.brightness = 8'($urandom_range(0, 255));
      bus.colour_vld = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    bus.colour_vld = 1'b0;

    // Prescale 4: counter steps every 4 cycles, first fade step after 1024
    chk_en = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    bus4.colour_in  = WHITE;
    bus4.brightness = 8'd255;
    bus4.colour_vld = 1'b1;
    k = 0;
    while (k < 1024) begin
      @(negedge clk);
      bus4.colour_vld = 1'b0;
      k++;
      if (k <= 40 || k == 1023) chk($sformatf("p4_cnt_k%0d", k), int'(dut4.pwm_cnt_q), (k / 4) % 256);
      if (k == 1023) chk("p4_duty_before", int'(dut4.u_ch_r.duty), 0);
      if (k == 2) chk("p4_busy", int'(bus4.busy), 1);
    end
    chk("p4_duty_after", int'(dut4.u_ch_g.duty), 64);
    chk("p4_colour_cur", int'(bus4.colour_cur), 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
